hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller: the single producer of every `freez` and bubble strobe that the stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) consume.
- Shadows the destination/control fields latched into the ID/EXE and EXE/MEM registers.
- Detects read-after-write hazards for the instruction in ID and inserts bubbles.
- Freezes the whole pipeline while a multi-cycle SRAM access occupies MEM.
- Gates the ID-resolved branch flush.

## Interface
Parameters:
- `MEM_WAIT`, 4: SRAM cycles per load/store; ≥1.
- `FW_EN`, 1: 1 = forwarding unit present (only load-use stalls); 0 = stall on any EXE/MEM producer.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `id_src1` in 5: ID source register 1.
- `id_src2` in 5: ID source register 2.
- `id_two_src` in 1: instruction reads `id_src2` as a register (R-type, store, branch compare).
- `id_dest` in 5: ID destination register.
- `id_wb_en` in 1: ID instruction writes back.
- `id_mem_r_en` in 1: ID instruction is a load.
- `id_mem_w_en` in 1: ID instruction is a store.
- `id_br_taken` in 1: branch taken, resolved in ID.
- `freez_front` out 1: hold PC and IF/ID.
- `freez_back` out 1: hold ID/EXE, EXE/MEM, MEM/WB.
- `bubble` out 1: ID/EXE loads all-zero controls (NOP) this edge.
- `flush_if` out 1: IF/ID loads NOP this edge.
- `mem_busy` out 1: SRAM access in progress (debug/SRAM controller qualifier).

## Operation
Shadow registers:
- `exe_dest`, `exe_wb_en`, `exe_mem_r_en`, `exe_mem_acc`.
- `mem_dest`, `mem_wb_en`, `mem_mem_acc`.

RAW hazard (`raw`), combinational:
- Match when `id_src1 != 0`, or `id_two_src && id_src2 != 0`, equals:
  - `exe_dest` with `exe_wb_en`, and additionally `exe_mem_r_en` when `FW_EN=1`; or
  - `mem_dest` with `mem_wb_en`, only when `FW_EN=0`.
- Register 0 never hazards.
- The register file is write-before-read, so WB is not tracked.

Memory-wait FSM (`IDLE`, `BUSY`), with counter `cnt` of `$clog2(MEM_WAIT)` bits (min 1):
- `IDLE` with `mem_mem_acc && MEM_WAIT>1`: `stall` = 1; go to `BUSY`, `cnt` ← `MEM_WAIT-2`.
- `BUSY` with `cnt != 0`: `stall` = 1, `cnt` decrements.
- `BUSY` with `cnt == 0`: `stall` = 0 (release cycle); go to `IDLE`. The pipeline advances, so the same access is not re-triggered.
- `mem_busy` = `stall`.

Outputs:
- `freez_back` = `stall`.
- `freez_front` = `stall | raw`.
- `bubble` = `raw & ~stall`.
- `flush_if` = `id_br_taken & ~raw & ~stall`.
- A branch waiting on its operands does not flush.

Shadow update at each edge:
- `stall` = 1: all shadows hold.
- Otherwise: MEM shadow ← EXE shadow. EXE shadow ← ID fields, or zeros if `raw`.
- `exe_mem_acc` = `id_mem_r_en | id_mem_w_en`.

## Timing
- Reset (`rst`=0, asynchronous): FSM `IDLE`, `cnt`=0, all shadows 0, all outputs 0.
- Reset asserted mid-`BUSY` aborts the wait immediately.
- Hazard outputs are combinational from ID inputs and registered state; zero-cycle latency.
- A load in MEM with `MEM_WAIT=N` gives `freez_back`=1 for exactly N-1 consecutive cycles, starting the first cycle it is in MEM.
- `MEM_WAIT=1`: never stalls.
- Simultaneous stall and raw: stall wins, `bubble`=0. Raw is re-evaluated after release.
- Back-to-back memory accesses stall independently, N-1 cycles each.

## Structure
- `hazard_pkg`: FSM state enum and `NOP_DEST`/zero-control constants.
- One sub-module, `mem_wait_fsm`: `clk`, `rst`, `mem_acc` → `stall`.
- RAW compare and shadow registers stay in the top module.

## Test plan
- `FW_EN=0`: `add r3` then `sub r4,r3,r5` → `freez_front`=1 and `bubble`=1 for 2 cycles, then `sub` proceeds.
- `FW_EN=1`: `lw r3` then `add r4,r3,r1` → exactly 1 bubble. `add r3` then `add r4,r3,r1` → 0 bubbles.
- Sources are r0 while EXE writes r0 (`wb_en`=1) → no stall. `id_two_src`=0 with `id_src2` matching → no stall.
- `MEM_WAIT=4`: `sw` reaches MEM → `freez_back`=1 for 3 cycles, 0 on the 4th. A following `lw` → another 3 cycles.
- Taken branch whose `id_src1` matches an EXE load (`FW_EN=1`) → `flush_if`=0 with bubble; next cycle `flush_if`=1.
- `rst` low during `BUSY` (`cnt`=1) → all outputs 0 immediately, FSM `IDLE`. After release, a fresh access stalls the full N-1 cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/stall controller
// Provides the memory-wait FSM state enum, the shadow-register layouts for the
// ID/EXE and EXE/MEM copies, their NOP (all-zero control) values and the
// register-match helper used by the RAW compare.
package hazard_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mw_state_e;

    localparam logic [4:0] NOP_DEST = 5'd0;

    typedef struct packed {
        logic [4:0] dest;
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_acc;
    } exe_shadow_t;

    typedef struct packed {
        logic [4:0] dest;
        logic       wb_en;
        logic       mem_acc;
    } mem_shadow_t;

    localparam exe_shadow_t EXE_NOP = '{dest: NOP_DEST, wb_en: 1'b0, mem_r_en: 1'b0, mem_acc: 1'b0};
    localparam mem_shadow_t MEM_NOP = '{dest: NOP_DEST, wb_en: 1'b0, mem_acc: 1'b0};

    // r0 is hard-wired, so a read of r0 can never depend on an older writer.
    function automatic logic reg_hit(input logic [4:0] src, input logic src_used,
                                     input logic [4:0] dest);
        return src_used && (src != 5'd0) && (src == dest);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// rtl/mem_wait_fsm.sv - holds the pipeline while a multi-cycle SRAM access sits in MEM
// Ports: clk, rst (async active-low), mem_acc (access in MEM stage),
//        stall (combinational: freeze the pipeline this cycle).
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_acc,
    output logic stall
);

    localparam int              CW        = (MEM_WAIT > 2) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0]   CNT_LOAD  = CW'((MEM_WAIT >= 2) ? MEM_WAIT - 2 : 0);
    localparam bit              CAN_STALL = (MEM_WAIT > 1);

    mw_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The IDLE cycle that sees the access is already the first stall cycle;
    // BUSY then adds MEM_WAIT-2 more, and the cnt==0 cycle releases so the
    // pipeline moves the access out of MEM before it can re-trigger.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CAN_STALL && mem_acc) begin
                    stall   = 1'b1;
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard and stall controller (freeze/bubble/flush source)
// Ports: clk, rst (async active-low); ID fields id_src1/id_src2/id_two_src/
//        id_dest/id_wb_en/id_mem_r_en/id_mem_w_en/id_br_taken;
//        outputs freez_front, freez_back, bubble, flush_if, mem_busy.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_WAIT = 4,
    parameter int FW_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_src1,
    input  logic [4:0] id_src2,
    input  logic       id_two_src,
    input  logic [4:0] id_dest,
    input  logic       id_wb_en,
    input  logic       id_mem_r_en,
    input  logic       id_mem_w_en,
    input  logic       id_br_taken,
    output logic       freez_front,
    output logic       freez_back,
    output logic       bubble,
    output logic       flush_if,
    output logic       mem_busy
);

    localparam bit FWD = (FW_EN != 0);

    exe_shadow_t exe_q, exe_d;
    mem_shadow_t mem_q, mem_d;
    logic        stall;
    logic        raw;
    logic        exe_prod;
    logic        mem_prod;

    // With forwarding only a load in EXE cannot supply its value in time;
    // without it, any writer still in EXE or MEM must drain first.
    assign exe_prod = exe_q.wb_en && (!FWD || exe_q.mem_r_en);
    assign mem_prod = !FWD && mem_q.wb_en;

    assign raw = (exe_prod && (reg_hit(id_src1, 1'b1, exe_q.dest) ||
                               reg_hit(id_src2, id_two_src, exe_q.dest))) ||
                 (mem_prod && (reg_hit(id_src1, 1'b1, mem_q.dest) ||
                               reg_hit(id_src2, id_two_src, mem_q.dest)));

    mem_wait_fsm #(
        .MEM_WAIT (MEM_WAIT)
    ) u_mem_wait (
        .clk     (clk),
        .rst     (rst),
        .mem_acc (mem_q.mem_acc),
        .stall   (stall)
    );

    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        if (!stall) begin
            mem_d.dest    = exe_q.dest;
            mem_d.wb_en   = exe_q.wb_en;
            mem_d.mem_acc = exe_q.mem_acc;
            if (raw) begin
                exe_d = EXE_NOP;
            end else begin
                exe_d.dest     = id_dest;
                exe_d.wb_en    = id_wb_en;
                exe_d.mem_r_en = id_mem_r_en;
                exe_d.mem_acc  = id_mem_r_en | id_mem_w_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_q <= EXE_NOP;
            mem_q <= MEM_NOP;
        end else begin
            exe_q <= exe_d;
            mem_q <= mem_d;
        end
    end

    assign freez_back  = stall;
    assign mem_busy    = stall;
    assign freez_front = stall | raw;
    assign bubble      = raw & ~stall;
    // flush_if is the only output driven straight from an ID input, so it is
    // gated by reset to keep every strobe quiet while reset is held.
    assign flush_if    = id_br_taken & ~raw & ~stall & rst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl over three configurations
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_src1, id_src2, id_dest;
    logic       id_two_src, id_wb_en, id_mem_r_en, id_mem_w_en, id_br_taken;
    logic [2:0] ff, fb, bu, fl, mb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // cfg0: no forwarding, 4-cycle SRAM; cfg1: forwarding, 4-cycle; cfg2: forwarding, 1-cycle
    hazard_ctrl #(.MEM_WAIT(4), .FW_EN(0)) u_c0 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
        .id_br_taken(id_br_taken), .freez_front(ff[0]), .freez_back(fb[0]), .bubble(bu[0]),
        .flush_if(fl[0]), .mem_busy(mb[0]));
    hazard_ctrl #(.MEM_WAIT(4), .FW_EN(1)) u_c1 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
        .id_br_taken(id_br_taken), .freez_front(ff[1]), .freez_back(fb[1]), .bubble(bu[1]),
        .flush_if(fl[1]), .mem_busy(mb[1]));
    hazard_ctrl #(.MEM_WAIT(1), .FW_EN(1)) u_c2 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
        .id_br_taken(id_br_taken), .freez_front(ff[2]), .freez_back(fb[2]), .bubble(bu[2]),
        .flush_if(fl[2]), .mem_busy(mb[2]));

    // Reference model: which instruction occupies EXE and MEM, and how many
    // more stall cycles the access in MEM still owes.
    int exe_dest [3];
    bit exe_wb   [3];
    bit exe_ld   [3];
    bit exe_acc  [3];
    int mem_dest [3];
    bit mem_wb   [3];
    bit mem_acc  [3];
    int owed     [3];

    int bub_cnt [3];
    int fb_cnt  [3];
    int fl_cnt  [3];

    function automatic int cfg_fw(int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic int cfg_n(int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit reads(int r);
        return (r != 0) && (r == int'(id_src1) || (id_two_src && r == int'(id_src2)));
    endfunction

    function automatic bit m_raw(int k);
        bit h;
        h = exe_wb[k] && (cfg_fw(k) == 0 || exe_ld[k]) && reads(exe_dest[k]);
        if (cfg_fw(k) == 0 && mem_wb[k] && reads(mem_dest[k])) h = 1'b1;
        return h;
    endfunction

    function automatic bit m_stall(int k);
        return mem_acc[k] && owed[k] > 0;
    endfunction

    // {freez_front, freez_back, bubble, flush_if, mem_busy}
    function automatic logic [4:0] m_out(int k);
        bit s, r;
        if (!rst) return 5'b0;
        s = m_stall(k);
        r = m_raw(k);
        return {s | r, s, r & !s, id_br_taken & !r & !s, s};
    endfunction

    function automatic logic [4:0] got(int k);
        return {ff[k], fb[k], bu[k], fl[k], mb[k]};
    endfunction

    task automatic m_edge();
        for (int k = 0; k < 3; k++) begin
            bit s, r;
            if (!rst) begin
                exe_dest[k] = 0; exe_wb[k] = 0; exe_ld[k] = 0; exe_acc[k] = 0;
                mem_dest[k] = 0; mem_wb[k] = 0; mem_acc[k] = 0; owed[k] = 0;
            end else begin
                s = m_stall(k);
                r = m_raw(k);
                if (s) begin
                    owed[k] = owed[k] - 1;
                end else begin
                    mem_dest[k] = exe_dest[k];
                    mem_wb[k]   = exe_wb[k];
                    mem_acc[k]  = exe_acc[k];
                    owed[k]     = exe_acc[k] ? cfg_n(k) - 1 : 0;
                    if (r) begin
                        exe_dest[k] = 0; exe_wb[k] = 0; exe_ld[k] = 0; exe_acc[k] = 0;
                    end else begin
                        exe_dest[k] = int'(id_dest);
                        exe_wb[k]   = id_wb_en;
                        exe_ld[k]   = id_mem_r_en;
                        exe_acc[k]  = id_mem_r_en | id_mem_w_en;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            logic [4:0] e;
            e = m_out(k);
            checks++;
            assert (got(k) === e) else begin
                errors++;
                $error("FAIL %s cfg%0d {ff,fb,bub,fl,busy} got %b expected %b", tag, k, got(k), e);
            end
        end
    endtask

    task automatic expect_cnt(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic cyc(input string tag);
        #1;
        check_all(tag);
        for (int k = 0; k < 3; k++) begin
            bub_cnt[k] += int'(bu[k]);
            fb_cnt[k]  += int'(fb[k]);
            fl_cnt[k]  += int'(fl[k]);
        end
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic set_in(input int s1, input int s2, input bit two, input int dest,
                          input bit wb, input bit rd, input bit wr, input bit br);
        id_src1     = 5'(s1);
        id_src2     = 5'(s2);
        id_two_src  = two;
        id_dest     = 5'(dest);
        id_wb_en    = wb;
        id_mem_r_en = rd;
        id_mem_w_en = wr;
        id_br_taken = br;
    endtask

    task automatic clr_cnt();
        for (int k = 0; k < 3; k++) begin
            bub_cnt[k] = 0; fb_cnt[k] = 0; fl_cnt[k] = 0;
        end
    endtask

    // Present one instruction in ID until configuration p lets it leave.
    task automatic issue(input string tag, input int p, input int s1, input int s2, input bit two,
                         input int dest, input bit wb, input bit rd, input bit wr, input bit br);
        bit done;
        done = 1'b0;
        set_in(s1, s2, two, dest, wb, rd, wr, br);
        for (int i = 0; i < 20; i++) begin
            if (!done) begin
                logic [4:0] e;
                e = m_out(p);
                cyc(tag);
                if (!e[4]) done = 1'b1;
            end
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL %s_timeout got held expected released", tag);
        end
    endtask

    task automatic drain();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (8) cyc("drain");
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("reset");
        set_in(3, 0, 0, 0, 0, 0, 0, 1);
        #1;
        check_all("reset_br");
        @(posedge clk);
        m_edge();
        @(negedge clk);
        rst = 1'b1;
        drain();

        // No forwarding: add r3 ; sub r4,r3,r5 -> two bubbles
        clr_cnt();
        issue("add_r3", 0, 1, 2, 1, 3, 1, 0, 0, 0);
        issue("sub_nofw", 0, 3, 5, 1, 4, 1, 0, 0, 0);
        drain();
        expect_cnt("nofw_bubbles", bub_cnt[0], 2);
        expect_cnt("fw_alu_bubbles", bub_cnt[1], 0);

        // Forwarding: lw r3 ; add r4,r3,r1 -> one bubble
        clr_cnt();
        issue("lw_r3", 1, 1, 0, 0, 3, 1, 1, 0, 0);
        issue("add_loaduse", 1, 3, 1, 1, 4, 1, 0, 0, 0);
        drain();
        expect_cnt("loaduse_bubbles", bub_cnt[1], 1);
        expect_cnt("loaduse_bubbles_w1", bub_cnt[2], 1);

        // Forwarding: add r3 ; add r4,r3,r1 -> no bubble
        clr_cnt();
        issue("add_r3b", 1, 1, 2, 1, 3, 1, 0, 0, 0);
        issue("add_fwd", 1, 3, 1, 1, 4, 1, 0, 0, 0);
        drain();
        expect_cnt("fwd_bubbles", bub_cnt[1], 0);

        // r0 never hazards; unused src2 never hazards
        clr_cnt();
        issue("wr_r0", 0, 1, 2, 1, 0, 1, 0, 0, 0);
        issue("rd_r0", 0, 0, 0, 1, 5, 1, 0, 0, 0);
        drain();
        issue("wr_r7", 0, 1, 2, 1, 7, 1, 1, 0, 0);
        issue("src2_unused", 0, 2, 7, 0, 6, 1, 0, 0, 0);
        drain();
        expect_cnt("r0_bubbles_c0", bub_cnt[0], 0);
        expect_cnt("r0_bubbles_c1", bub_cnt[1], 0);
        expect_cnt("r0_bubbles_c2", bub_cnt[2], 0);

        // sw then lw: each access stalls N-1 cycles, MEM_WAIT=1 never stalls
        clr_cnt();
        issue("sw", 1, 1, 2, 1, 0, 0, 0, 1, 0);
        issue("lw_after_sw", 1, 1, 0, 0, 3, 1, 1, 0, 0);
        drain();
        expect_cnt("memwait_c0", fb_cnt[0], 6);
        expect_cnt("memwait_c1", fb_cnt[1], 6);
        expect_cnt("memwait_c2", fb_cnt[2], 0);

        // Taken branch waiting on a load: bubble first, flush next cycle
        clr_cnt();
        issue("lw_br", 2, 1, 0, 0, 3, 1, 1, 0, 0);
        issue("br_dep", 2, 3, 0, 1, 0, 0, 0, 0, 1);
        drain();
        expect_cnt("br_flushes", fl_cnt[2], 1);
        expect_cnt("br_bubbles", bub_cnt[2], 1);

        // Async reset while BUSY with cnt==1
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        cyc("sw_id");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("sw_exe");
        cyc("sw_mem1");
        cyc("sw_mem2");
        set_in(3, 0, 0, 0, 0, 0, 0, 1);
        #1;
        check_all("busy_cnt1");
        #1;
        rst = 1'b0;
        #1;
        check_all("async_rst");
        expect_cnt("async_rst_busy", int'(mb[1]), 0);
        @(posedge clk);
        m_edge();
        @(negedge clk);
        rst = 1'b1;
        clr_cnt();
        issue("lw_fresh", 1, 1, 0, 0, 3, 1, 1, 0, 0);
        drain();
        expect_cnt("fresh_stall_c0", fb_cnt[0], 3);
        expect_cnt("fresh_stall_c1", fb_cnt[1], 3);

        // Randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 7);
            rst = (i == 200) ? 1'b0 : 1'b1;
            set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), r == 0, r == 1,
                   $urandom_range(0, 7) == 0);
            cyc("random");
        end
        rst = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
